// File: rtl/neureka_infeat_buffer_reader_pkg.sv
// ============================================================================
// Module  : neureka_infeat_reader_pkg
// Brief   : Shared types and defaults for the input-feature buffer reader:
//           FSM state encoding, latched window configuration, size defaults.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package neureka_infeat_reader_pkg;

  // Default geometry of the input-feature buffer (8 x 8 words).
  localparam int BUF_W_DEF      = 8;
  localparam int DIM_WIDTH_DEF  = 4;
  localparam int ADDR_WIDTH_DEF = 6;

  // Walk sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Window description captured when a walk is accepted.
  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] row_base;
    logic [ADDR_WIDTH_DEF-1:0] col_base;
    logic [DIM_WIDTH_DEF-1:0]  rows;
    logic [DIM_WIDTH_DEF-1:0]  cols;
    logic [DIM_WIDTH_DEF-1:0]  valid_rows;
    logic [DIM_WIDTH_DEF-1:0]  valid_cols;
  } cfg_t;

  // A window with either extent zero produces no beats.
  function automatic logic extent_nonzero(input logic [DIM_WIDTH_DEF-1:0] rows,
                                          input logic [DIM_WIDTH_DEF-1:0] cols);
    return (rows != '0) && (cols != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/neureka_infeat_buffer_reader_if.sv
// ============================================================================
// Module  : neureka_infeat_buffer_reader_if
// Brief   : Control, buffer and output-stream bundle of the buffer reader.
//           slave = reader side, master = controller / consumer side.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface neureka_infeat_buffer_reader_if
  import neureka_infeat_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_WORDS  = 64,
  parameter int ADDR_WIDTH = $clog2(NUM_WORDS),
  parameter int DIM_WIDTH  = DIM_WIDTH_DEF
);

  // Control / window description
  logic                            clear_i;
  logic                            start_i;
  logic [ADDR_WIDTH-1:0]           row_base_i;
  logic [ADDR_WIDTH-1:0]           col_base_i;
  logic [DIM_WIDTH-1:0]            rows_i;
  logic [DIM_WIDTH-1:0]            cols_i;
  logic [DIM_WIDTH-1:0]            valid_rows_i;
  logic [DIM_WIDTH-1:0]            valid_cols_i;
  // Flat buffer contents
  logic [NUM_WORDS*DATA_WIDTH-1:0] infeat_buffer_i;
  // Output stream and status
  logic [DATA_WIDTH-1:0]           data_o;
  logic [ADDR_WIDTH-1:0]           addr_o;
  logic                            valid_o;
  logic                            ready_i;
  logic                            last_o;
  logic                            busy_o;
  logic                            done_o;

  modport slave (
    input  clear_i, start_i, row_base_i, col_base_i, rows_i, cols_i,
           valid_rows_i, valid_cols_i, infeat_buffer_i, ready_i,
    output data_o, addr_o, valid_o, last_o, busy_o, done_o
  );

  modport master (
    output clear_i, start_i, row_base_i, col_base_i, rows_i, cols_i,
           valid_rows_i, valid_cols_i, infeat_buffer_i, ready_i,
    input  data_o, addr_o, valid_o, last_o, busy_o, done_o
  );

endinterface

`default_nettype wire

// File: rtl/neureka_infeat_buffer_reader_addrgen.sv
// ============================================================================
// Module  : neureka_infeat_reader_addrgen
// Brief   : Row-major r/c window counters, wrapped buffer address, last and
//           padding flags. Counters advance on en_i and rest at (0,0).
//           Optional: NEUREKA_INFEAT_READER_ZERO_PAD_EN enables the pad flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module neureka_infeat_reader_addrgen
  import neureka_infeat_reader_pkg::*;
#(
  parameter int BUF_W = BUF_W_DEF
) (
  input  wire                       clk_i,
  input  wire                       rst_ni,
  input  wire                       clear_i,
  input  wire                       en_i,
  input  cfg_t                      cfg_i,
  output logic [ADDR_WIDTH_DEF-1:0] addr_o,
  output logic                      last_o,
  output logic                      pad_o
);

  localparam int BUF_W_LOG2 = $clog2(BUF_W);

  logic [DIM_WIDTH_DEF-1:0]  r_q, r_d;
  logic [DIM_WIDTH_DEF-1:0]  c_q, c_d;
  logic [ADDR_WIDTH_DEF-1:0] row_sum;
  logic                      last_col;
  logic                      last_row;

  // Address of the current window position; truncation gives the wrap-around.
  always_comb begin
    row_sum  = cfg_i.row_base + ADDR_WIDTH_DEF'(r_q);
    addr_o   = (row_sum << BUF_W_LOG2) + cfg_i.col_base + ADDR_WIDTH_DEF'(c_q);
    last_col = (c_q == cfg_i.cols - 1'b1);
    last_row = (r_q == cfg_i.rows - 1'b1);
    last_o   = last_col & last_row;
  end

`ifdef NEUREKA_INFEAT_READER_ZERO_PAD_EN
  // Positions outside the real-data sub-window are padding.
  always_comb begin
    pad_o = (r_q >= cfg_i.valid_rows) | (c_q >= cfg_i.valid_cols);
  end
`else
  logic unused_valid_dims;
  assign unused_valid_dims = ^{cfg_i.valid_rows, cfg_i.valid_cols};
  assign pad_o             = 1'b0;
`endif

  // Row-major advance; the final position returns the counters to (0,0).
  always_comb begin
    r_d = r_q;
    c_d = c_q;
    if (clear_i) begin
      r_d = '0;
      c_d = '0;
    end else if (en_i) begin
      if (last_o) begin
        r_d = '0;
        c_d = '0;
      end else if (last_col) begin
        c_d = '0;
        r_d = r_q + 1'b1;
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q <= '0;
      c_q <= '0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/neureka_infeat_buffer_reader.sv
// ============================================================================
// Module  : neureka_infeat_buffer_reader
// Brief   : Read-side sequencer of the input-feature buffer. Walks a window
//           row-major and streams one word per beat (valid/ready), with last
//           flag, done pulse and busy indication.
//           Optional: NEUREKA_INFEAT_READER_ZERO_PAD_EN zeroes padded beats.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module neureka_infeat_buffer_reader
  import neureka_infeat_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_WORDS  = 64,
  parameter int BUF_W      = BUF_W_DEF,
  parameter int ADDR_WIDTH = $clog2(NUM_WORDS),
  parameter int DIM_WIDTH  = DIM_WIDTH_DEF
) (
  input  wire                           clk_i,
  input  wire                           rst_ni,
  neureka_infeat_buffer_reader_if.slave bus
);

  state_e                    state_q, state_d;
  cfg_t                      cfg_q, cfg_d;
  cfg_t                      cfg_in;
  cfg_t                      cfg_sel;
  logic                      valid_q, valid_d;
  logic                      last_q, last_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [ADDR_WIDTH_DEF-1:0] addr_q, addr_d;
  logic                      load;
  logic                      handshake;
  logic [ADDR_WIDTH_DEF-1:0] gen_addr;
  logic                      gen_last;
  logic                      pad;
  logic [DATA_WIDTH-1:0]     word;
  logic [DATA_WIDTH-1:0]     words [NUM_WORDS];

  // View the flat buffer as an indexable word array.
  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_words
    assign words[i] = bus.infeat_buffer_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Window description presented on the inputs this cycle.
  always_comb begin
    cfg_in            = '0;
    cfg_in.row_base   = bus.row_base_i;
    cfg_in.col_base   = bus.col_base_i;
    cfg_in.rows       = bus.rows_i;
    cfg_in.cols       = bus.cols_i;
`ifdef NEUREKA_INFEAT_READER_ZERO_PAD_EN
    cfg_in.valid_rows = bus.valid_rows_i;
    cfg_in.valid_cols = bus.valid_cols_i;
`endif
  end

`ifndef NEUREKA_INFEAT_READER_ZERO_PAD_EN
  logic unused_valid_dims_in;
  assign unused_valid_dims_in = ^{bus.valid_rows_i, bus.valid_cols_i};
`endif

  // The first beat is loaded in the start cycle, before the config register
  // holds the window, so the generator sees the live inputs while idle.
  assign cfg_sel = (state_q == ST_IDLE) ? cfg_in : cfg_q;

  neureka_infeat_reader_addrgen #(
    .BUF_W (BUF_W)
  ) u_addrgen (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (bus.clear_i),
    .en_i    (load),
    .cfg_i   (cfg_sel),
    .addr_o  (gen_addr),
    .last_o  (gen_last),
    .pad_o   (pad)
  );

  // Word selected by the generator, forced to zero on padding beats.
`ifdef NEUREKA_INFEAT_READER_ZERO_PAD_EN
  assign word = pad ? '0 : words[gen_addr];
`else
  logic unused_pad;
  assign unused_pad = pad;
  assign word       = words[gen_addr];
`endif

  assign handshake = valid_q & bus.ready_i;

  // Next-state, config capture and output-register load decisions.
  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    addr_d  = addr_q;
    load    = 1'b0;

    if (bus.clear_i) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start_i) begin
            cfg_d = cfg_in;
            if (extent_nonzero(cfg_in.rows, cfg_in.cols)) begin
              load    = 1'b1;
              state_d = gen_last ? ST_DRAIN : ST_RUN;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_RUN: begin
          // Register is refilled whenever it is empty or being consumed.
          if (!valid_q || bus.ready_i) begin
            load = 1'b1;
            if (gen_last) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (handshake) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      if (load) begin
        valid_d = 1'b1;
        data_d  = word;
        addr_d  = gen_addr;
        last_d  = gen_last;
      end
    end
  end

  // State, config and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.last_o  = last_q;
  assign bus.data_o  = data_q;
  assign bus.addr_o  = ADDR_WIDTH'(addr_q);
  assign bus.busy_o  = (state_q != ST_IDLE);
  assign bus.done_o  = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_neureka_infeat_buffer_reader.sv
// ============================================================================
// Module  : tb_neureka_infeat_buffer_reader
// Brief   : Directed bench for the input-feature buffer reader with an
//           expected-beat queue filled from a reference address/data model.
//           Follows NEUREKA_INFEAT_READER_ZERO_PAD_EN for padded expectations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_neureka_infeat_buffer_reader;

  localparam int DW = 128;
  localparam int NW = 64;
  localparam int BW = 8;
  localparam int AW = 6;
  localparam int DIM = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk;
  logic rst_n;
  logic [DW-1:0] mem [NW];
  beat_t sb [$];
  int checks = 0;
  int errors = 0;

  neureka_infeat_buffer_reader_if #(
    .DATA_WIDTH (DW),
    .NUM_WORDS  (NW),
    .ADDR_WIDTH (AW),
    .DIM_WIDTH  (DIM)
  ) bus ();

  neureka_infeat_buffer_reader #(
    .DATA_WIDTH (DW),
    .NUM_WORDS  (NW),
    .BUF_W      (BW),
    .ADDR_WIDTH (AW),
    .DIM_WIDTH  (DIM)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push the expected beats of a window and pulse start (called at a negedge).
  task automatic launch(input int rb, input int cb, input int rows, input int cols,
                        input int vr, input int vc);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        beat_t b;
        bit    is_pad;
        b.addr = AW'(((rb + r) * BW + cb + c) % NW);
`ifdef NEUREKA_INFEAT_READER_ZERO_PAD_EN
        is_pad = (r >= vr) || (c >= vc);
`else
        is_pad = 1'b0;
`endif
        b.data = is_pad ? '0 : mem[b.addr];
        b.last = (r == rows - 1) && (c == cols - 1);
        sb.push_back(b);
      end
    end
    bus.row_base_i   = AW'(rb);
    bus.col_base_i   = AW'(cb);
    bus.rows_i       = DIM'(rows);
    bus.cols_i       = DIM'(cols);
    bus.valid_rows_i = DIM'(vr);
    bus.valid_cols_i = DIM'(vc);
    bus.start_i      = 1'b1;
  endtask

  // Run one window to completion; stall toggles ready 1,0,0; clear_beat>0
  // aborts with ready low while that beat is presented.
  task automatic walk(input string tag, input int rb, input int cb, input int rows,
                      input int cols, input int vr, input int vc,
                      input bit stall, input int clear_beat);
    int n      = 0;
    int popped = 0;
    launch(rb, cb, rows, cols, vr, vc);
    while (sb.size() > 0 && n < 64) begin
      @(negedge clk);
      if (n == 0) begin
        bus.start_i    = 1'b0;
        bus.row_base_i = '1;
        bus.col_base_i = '1;
        bus.rows_i     = '1;
        bus.cols_i     = '1;
        chk({tag, "_first_valid"}, DW'(bus.valid_o), DW'(1));
        chk({tag, "_busy"}, DW'(bus.busy_o), DW'(1));
        chk({tag, "_no_done"}, DW'(bus.done_o), DW'(0));
      end
      bus.ready_i = stall ? ((n % 3) == 0) : 1'b1;
      if (clear_beat != 0 && popped == clear_beat - 1) begin
        bus.ready_i = 1'b0;
        bus.clear_i = 1'b1;
        chk({tag, "_held_addr"}, DW'(bus.addr_o), DW'(sb[0].addr));
        @(negedge clk);
        bus.clear_i = 1'b0;
        bus.ready_i = 1'b1;
        chk({tag, "_clr_valid"}, DW'(bus.valid_o), DW'(0));
        chk({tag, "_clr_busy"}, DW'(bus.busy_o), DW'(0));
        chk({tag, "_clr_done"}, DW'(bus.done_o), DW'(0));
        chk({tag, "_clr_last"}, DW'(bus.last_o), DW'(0));
        sb.delete();
        @(negedge clk);
        chk({tag, "_clr_no_done"}, DW'(bus.done_o), DW'(0));
        return;
      end
      if (bus.valid_o) begin
        chk($sformatf("%s_b%0d_addr", tag, popped), DW'(bus.addr_o), DW'(sb[0].addr));
        chk($sformatf("%s_b%0d_data", tag, popped), bus.data_o, sb[0].data);
        chk($sformatf("%s_b%0d_last", tag, popped), DW'(bus.last_o), DW'(sb[0].last));
        if (bus.ready_i) begin
          void'(sb.pop_front());
          popped++;
        end
      end
      n++;
    end
    if (n >= 64) begin
      chk({tag, "_timeout_left"}, DW'(sb.size()), DW'(0));
      sb.delete();
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    chk({tag, "_done_pulse"}, DW'(bus.done_o), DW'(1));
    chk({tag, "_done_novalid"}, DW'(bus.valid_o), DW'(0));
    @(negedge clk);
    chk({tag, "_after_done"}, DW'(bus.done_o), DW'(0));
    chk({tag, "_after_busy"}, DW'(bus.busy_o), DW'(0));
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      mem[i] = {32'hC0DE0000 | 32'(i), ~32'(i), 32'(i * 3 + 1), 32'h5A5A0000 | 32'(i)};
      bus.infeat_buffer_i[i*DW +: DW] = mem[i];
    end
    rst_n            = 1'b0;
    bus.clear_i      = 1'b0;
    bus.start_i      = 1'b0;
    bus.row_base_i   = '0;
    bus.col_base_i   = '0;
    bus.rows_i       = '0;
    bus.cols_i       = '0;
    bus.valid_rows_i = '0;
    bus.valid_cols_i = '0;
    bus.ready_i      = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", DW'(bus.valid_o), DW'(0));
    chk("rst_last", DW'(bus.last_o), DW'(0));
    chk("rst_busy", DW'(bus.busy_o), DW'(0));
    chk("rst_done", DW'(bus.done_o), DW'(0));
    chk("rst_addr", DW'(bus.addr_o), DW'(0));
    chk("rst_data", bus.data_o, DW'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Full-throughput walk, then the same window under back-pressure
    walk("base", 1, 2, 2, 3, 8, 8, 1'b0, 0);
    walk("stall", 1, 2, 2, 3, 8, 8, 1'b1, 0);

    // Zero-height window: done pulse only
    bus.rows_i  = '0;
    bus.cols_i  = DIM'(3);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    chk("zero_done", DW'(bus.done_o), DW'(1));
    chk("zero_valid", DW'(bus.valid_o), DW'(0));
    chk("zero_busy", DW'(bus.busy_o), DW'(1));
    @(negedge clk);
    chk("zero_done_end", DW'(bus.done_o), DW'(0));
    chk("zero_valid_end", DW'(bus.valid_o), DW'(0));
    chk("zero_busy_end", DW'(bus.busy_o), DW'(0));

    // Column spill and wrap to word 0
    walk("wrap", 7, 6, 2, 3, 8, 8, 1'b0, 0);

    // Abort at beat 3, then restart from beat 1
    walk("clr", 1, 2, 2, 3, 8, 8, 1'b0, 3);
    walk("restart", 1, 2, 2, 3, 8, 8, 1'b0, 0);

    // 3x3 window with a 2x2 real-data region
    walk("pad", 0, 0, 3, 3, 2, 2, 1'b0, 0);

    // Single-beat window
    walk("one", 5, 5, 1, 1, 8, 8, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/neureka_infeat_buffer_reader.md
Name: neureka_infeat_buffer_reader

Overview:
- Read-side sequencer for the latch-based input-feature buffer.
- Consumes the buffer's flat word array (NUM_WORDS x DATA_WIDTH) and walks a rectangular spatial window row-major.
- Emits one word per beat on a valid/ready stream towards the PE-array feeder, with a last flag and a done pulse.
- Owns the busy indication the load controller uses to hold off buffer writes.

Parameters:
DATA_WIDTH, 128, bits per buffer word
NUM_WORDS, 64, words in buffer; power of two
BUF_W, 8, buffer row length in words; power of two dividing NUM_WORDS
ADDR_WIDTH, 6, $clog2(NUM_WORDS)
DIM_WIDTH, 4, width of window extents (0..BUF_W)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous abort/clear, priority over everything except reset
start_i  in  1  launch window walk; sampled only in IDLE
row_base_i  in  ADDR_WIDTH  window origin row
col_base_i  in  ADDR_WIDTH  window origin column
rows_i  in  DIM_WIDTH  window height
cols_i  in  DIM_WIDTH  window width
valid_rows_i  in  DIM_WIDTH  rows of window holding real data (padding feature)
valid_cols_i  in  DIM_WIDTH  columns of window holding real data (padding feature)
infeat_buffer_i  in  NUM_WORDS*DATA_WIDTH  full buffer contents
data_o  out  DATA_WIDTH  stream word
addr_o  out  ADDR_WIDTH  buffer address of data_o
valid_o  out  1  stream valid
ready_i  in  1  stream ready
last_o  out  1  final beat of window; qualified by valid_o
busy_o  out  1  walk in progress
done_o  out  1  one-cycle pulse after last handshake

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters 0, config registers 0.
- Config latched on accepted start; inputs may change afterwards.
- FSM:
  - IDLE -> RUN on start_i with rows_i!=0 and cols_i!=0.
  - IDLE -> DONE on start_i with either extent 0.
  - RUN -> DRAIN when the final address has been loaded into the output register.
  - DRAIN -> DONE on valid_o & ready_i.
  - DONE -> IDLE unconditionally.
  - done_o = 1 exactly in DONE. busy_o = 1 in RUN, DRAIN and DONE.
- start_i outside IDLE is ignored.
- Address computation:
  - addr = ((row_base + r) * BUF_W + col_base + c) mod NUM_WORDS, with r in [0,rows), c in [0,cols).
  - Truncation to ADDR_WIDTH gives wrap-around: column overflow spills into the next row, row overflow wraps to word 0.
- Output register:
  - One entry; loaded when empty or when valid_o & ready_i in the same cycle. This gives full throughput: one beat per cycle when ready_i is held high.
  - First valid_o is asserted the cycle after the accepted start (latency 1).
  - data_o, addr_o and last_o are held stable while valid_o & !ready_i.
  - Data is sampled from infeat_buffer_i at load time.
  - Writer must not modify in-window words while busy_o; this is not checked.
- Counters: c increments per load; at cols-1 it wraps to 0 and r increments. last_o is set when r==rows-1 and c==cols-1.
- clear_i: next cycle FSM IDLE, valid_o=0, last_o=0, busy_o=0, no done_o pulse, counters 0. clear_i together with start_i: clear wins.

Optional Feature:
- Macro: NEUREKA_INFEAT_READER_ZERO_PAD_EN.
- Defined: a beat with r>=valid_rows or c>=valid_cols (latched values) outputs data_o='0. addr_o is still the computed address and timing is unchanged.
- Undefined: valid_rows_i/valid_cols_i are ignored and not registered; every beat reads the buffer.

Decomposition:
- Package neureka_infeat_reader_pkg holds:
  - the FSM state enum (IDLE, RUN, DRAIN, DONE)
  - a config struct (row_base, col_base, rows, cols, valid_rows, valid_cols)
  - BUF_W and DIM_WIDTH defaults.
- One sub-module, neureka_infeat_reader_addrgen: r/c counters, address arithmetic, last flag and pad flag, advancing on an enable input.
- Word mux and output register stay in the top.

Test Plan:
- Window base (1,2), 2x3, ready_i=1 -> valid_o from cycle 1, 6 consecutive beats, addr 10,11,12,18,19,20, data equal to buffer[addr], last_o on beat 6, done_o one cycle after beat 6, busy_o low after that.
- Same window with ready_i toggling 1,0,0,1... -> each beat held stable through stall cycles, same 6 addresses in order, no loss or duplication.
- start_i with rows_i=0, cols_i=3 -> no valid_o, done_o pulses on cycle 1 only.
- Base (7,6), 2x3 -> addr 62,63,0,6,7,8 (column spill plus wrap to 0).
- clear_i asserted at beat 3 with ready_i=0 -> next cycle valid_o=0 and busy_o=0, no done_o. A new start then walks from beat 1.
- Macro defined, 3x3 window at (0,0), valid_rows=2, valid_cols=2 -> beats at r=2 or c=2 carry zero data with addr 2,10,16,17,18; other beats carry buffer data. Macro undefined: all 9 beats carry buffer data.
